// File: rtl/generador_onda_cuadrada_pkg.sv
// +----------------------------------------------------------------------------+
// | gen_onda_pkg: state encoding and helpers for the square-wave generator      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package gen_onda_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ALTO = 2'd1,
    BAJO = 2'd2
  } estado_t;

  function automatic int unsigned clks_por_us(input int unsigned clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  function automatic logic config_valida(input int unsigned periodo,
                                         input int unsigned alto);
    return (periodo >= 2) && (alto >= 1) && (alto < periodo);
  endfunction

endpackage

`default_nettype wire

// File: rtl/generador_onda_cuadrada_prescaler.sv
// +----------------------------------------------------------------------------+
// | prescaler_us: divides the system clock down to a 1 us tick                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module prescaler_us
  import gen_onda_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
)(
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned c_CPU  = clks_por_us(CLK_FREQ_HZ);
  localparam int unsigned c_W    = (c_CPU > 1) ? $clog2(c_CPU) : 1;
  localparam logic [c_W-1:0] c_TERM = c_W'(c_CPU - 1);

  logic [c_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == c_TERM);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/generador_onda_cuadrada.sv
// +----------------------------------------------------------------------------+
// | generador_onda_cuadrada: programmable square wave, period/high time in us  |
// | Optional burst mode with macro GEN_RAFAGA_EN.  Rev 1.0                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module generador_onda_cuadrada
  import gen_onda_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
  parameter int unsigned PERIOD_W       = 16,
  parameter int unsigned DEF_PERIODO_US = 10,
  parameter int unsigned DEF_ALTO_US    = 5
)(
  input  logic                clock_FPGA,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] periodo_us,
  input  logic [PERIOD_W-1:0] alto_us,
  input  logic                cargar,
  input  logic                habilitar,
  output logic                onda_cuadrada,
  output logic                ciclo_fin,
  output logic                ocupado,
  output logic                config_error
`ifdef GEN_RAFAGA_EN
  ,
  input  logic [PERIOD_W-1:0] n_pulsos,
  output logic                rafaga_fin
`endif
);

  localparam logic [PERIOD_W-1:0] c_DEF_P = PERIOD_W'(DEF_PERIODO_US);
  localparam logic [PERIOD_W-1:0] c_DEF_A = PERIOD_W'(DEF_ALTO_US);

  estado_t             r_estado;
  logic [PERIOD_W-1:0] r_act_p, r_act_a, r_pend_p, r_pend_a, r_us;
  logic                r_onda, r_ocupado, r_err;

  logic                w_tick, w_valida, w_arranque, w_fin_alto, w_ultimo;
  logic                w_limite, w_sigue, w_bloqueo;
  logic [PERIOD_W-1:0] w_us_sig, w_nuevo_p, w_nuevo_a;

  assign w_valida   = config_valida(32'(periodo_us), 32'(alto_us));
  assign w_us_sig   = r_us + 1'b1;
  assign w_fin_alto = (r_estado == ALTO) && w_tick && (w_us_sig == r_act_a);
  assign w_ultimo   = (r_estado == BAJO) && w_tick && (w_us_sig == r_act_p);
  assign w_arranque = (r_estado == IDLE) && habilitar && !w_bloqueo;
  assign w_limite   = w_arranque || w_ultimo;

  // A load landing on the boundary cycle bypasses pending so it governs the next period.
  assign w_nuevo_p  = (cargar && w_valida) ? periodo_us : r_pend_p;
  assign w_nuevo_a  = (cargar && w_valida) ? alto_us    : r_pend_a;

  prescaler_us #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_prescaler (
    .clk    (clock_FPGA),
    .rst    (reset),
    .i_en   (r_estado != IDLE),
    .i_clr  ((r_estado == IDLE) || w_ultimo),
    .o_tick (w_tick)
  );

`ifdef GEN_RAFAGA_EN
  logic [PERIOD_W-1:0] r_n, r_hechos;
  logic                r_bloq;
  logic                w_rafaga_fin;

  assign w_rafaga_fin = w_ultimo && (r_n != '0) && ((r_hechos + 1'b1) == r_n);
  assign w_sigue      = habilitar && !w_rafaga_fin;
  assign w_bloqueo    = r_bloq;
  assign rafaga_fin   = w_rafaga_fin;

  always_ff @(posedge clock_FPGA) begin
    if (reset) begin
      r_n      <= '0;
      r_hechos <= '0;
      r_bloq   <= 1'b0;
    end else begin
      if (!habilitar) begin
        r_bloq <= 1'b0;
      end else if (w_rafaga_fin) begin
        r_bloq <= 1'b1;
      end
      if (w_arranque) begin
        r_n      <= n_pulsos;
        r_hechos <= '0;
      end else if (w_ultimo) begin
        r_hechos <= r_hechos + 1'b1;
      end
    end
  end
`else
  assign w_sigue   = habilitar;
  assign w_bloqueo = 1'b0;
`endif

  always_ff @(posedge clock_FPGA) begin
    if (reset) begin
      r_estado  <= IDLE;
      r_onda    <= 1'b0;
      r_ocupado <= 1'b0;
      r_us      <= '0;
    end else begin
      case (r_estado)
        IDLE: begin
          if (w_arranque) begin
            r_estado  <= ALTO;
            r_onda    <= 1'b1;
            r_ocupado <= 1'b1;
            r_us      <= '0;
          end
        end
        ALTO: begin
          if (w_tick) begin
            r_us <= w_us_sig;
            if (w_fin_alto) begin
              r_estado <= BAJO;
              r_onda   <= 1'b0;
            end
          end
        end
        BAJO: begin
          if (w_ultimo) begin
            r_us <= '0;
            if (w_sigue) begin
              r_estado <= ALTO;
              r_onda   <= 1'b1;
            end else begin
              r_estado  <= IDLE;
              r_ocupado <= 1'b0;
            end
          end else if (w_tick) begin
            r_us <= w_us_sig;
          end
        end
        default: begin
          r_estado  <= IDLE;
          r_onda    <= 1'b0;
          r_ocupado <= 1'b0;
          r_us      <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_FPGA) begin
    if (reset) begin
      r_pend_p <= c_DEF_P;
      r_pend_a <= c_DEF_A;
      r_act_p  <= c_DEF_P;
      r_act_a  <= c_DEF_A;
      r_err    <= 1'b0;
    end else begin
      if (cargar) begin
        if (w_valida) begin
          r_pend_p <= periodo_us;
          r_pend_a <= alto_us;
          r_err    <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (w_limite) begin
        r_act_p <= w_nuevo_p;
        r_act_a <= w_nuevo_a;
      end
    end
  end

  assign onda_cuadrada = r_onda;
  assign ocupado       = r_ocupado;
  assign config_error  = r_err;
  assign ciclo_fin     = w_ultimo;

endmodule

`default_nettype wire

// File: tb/tb_generador_onda_cuadrada.sv
// +----------------------------------------------------------------------------+
// | tb_generador_onda_cuadrada: directed + random stimulus vs. reference model |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_generador_onda_cuadrada;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int          CPU    = 50;
  localparam int          W      = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cargar = 1'b0;
  logic         hab = 1'b0;
  logic [W-1:0] per = '0;
  logic [W-1:0] alt = '0;
  logic         onda, cfin, ocup, cerr;
`ifdef GEN_RAFAGA_EN
  logic [W-1:0] npul = '0;
  logic         rfin;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  generador_onda_cuadrada #(
    .CLK_FREQ_HZ    (CLK_HZ),
    .PERIOD_W       (W),
    .DEF_PERIODO_US (10),
    .DEF_ALTO_US    (5)
  ) dut (
    .clock_FPGA    (clk),
    .reset         (rst),
    .periodo_us    (per),
    .alto_us       (alt),
    .cargar        (cargar),
    .habilitar     (hab),
    .onda_cuadrada (onda),
    .ciclo_fin     (cfin),
    .ocupado       (ocup),
    .config_error  (cerr)
`ifdef GEN_RAFAGA_EN
    ,
    .n_pulsos      (npul),
    .rafaga_fin    (rfin)
`endif
  );

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: position inside the current period, in clocks.
  bit m_run, m_bloq, m_err, chk_on;
  int m_j, m_P, m_A, m_pP, m_pA, m_n, m_done;

  always @(posedge clk) begin : modelo
    bit acc, last, start, raf;
    if (rst) begin
      m_run = 0; m_bloq = 0; m_err = 0; m_j = 0;
      m_P = 10; m_A = 5; m_pP = 10; m_pA = 5; m_n = 0; m_done = 0;
    end else begin
      acc   = cargar && (per >= 2) && (alt >= 1) && (alt < per);
      last  = m_run && (m_j == m_P * CPU - 1);
      raf   = last && (m_n != 0) && (m_done == m_n - 1);
      start = !m_run && hab && !m_bloq;
      if (start || last) begin
        m_P = acc ? int'(per) : m_pP;
        m_A = acc ? int'(alt) : m_pA;
      end
      if (start) begin
        m_run = 1; m_j = 0; m_done = 0;
`ifdef GEN_RAFAGA_EN
        m_n = int'(npul);
`endif
      end else if (last) begin
        m_done++;
        if (hab && !raf) m_j = 0;
        else m_run = 0;
      end else if (m_run) begin
        m_j++;
      end
      if (!hab) m_bloq = 0;
      else if (raf) m_bloq = 1;
      if (cargar) begin
        if (acc) begin m_pP = int'(per); m_pA = int'(alt); m_err = 0; end
        else m_err = 1;
      end
    end
    chk_on = 1;
  end

  // Run-length monitor of the wave for directed measurements.
  int   largos[$];
  int   run_len = 0;
  int   subidas = 0;
  int   rafagas = 0;
  logic prev = 1'b0;

  always @(negedge clk) begin
    bit e_onda, e_cfin;
    if (chk_on) begin
      e_onda = m_run && (m_j < m_A * CPU);
      e_cfin = m_run && (m_j == m_P * CPU - 1);
      chequear("onda", 32'(onda), 32'(e_onda));
      chequear("ciclo_fin", 32'(cfin), 32'(e_cfin));
      chequear("ocupado", 32'(ocup), 32'(m_run));
      chequear("config_error", 32'(cerr), 32'(m_err));
`ifdef GEN_RAFAGA_EN
      chequear("rafaga_fin", 32'(rfin), 32'(e_cfin && (m_n != 0) && (m_done == m_n - 1)));
      if (rfin === 1'b1) rafagas++;
`endif
      if (onda === prev) begin
        run_len++;
      end else begin
        largos.push_back(run_len);
        run_len = 1;
        if (onda === 1'b1) subidas++;
        prev = onda;
      end
    end
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic limpiar_monitor();
    @(posedge clk);
    largos.delete();
    run_len = 0;
    subidas = 0;
    rafagas = 0;
    @(negedge clk);
  endtask

  task automatic carga(input int p, input int a);
    per    = W'(p);
    alt    = W'(a);
    cargar = 1'b1;
    @(negedge clk);
    cargar = 1'b0;
  endtask

  task automatic reiniciar();
    hab = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b0;
    chequear("reset_onda", 32'(onda), 32'd0);
    chequear("reset_ocupado", 32'(ocup), 32'd0);

    // Defaults: 250 high / 250 low, rise on the edge that samples habilitar.
    limpiar_monitor();
    hab = 1'b1;
    @(negedge clk);
    chequear("primer_flanco", 32'(onda), 32'd1);
    ciclos(1100);
    chequear("def_alto1", 32'(largos[1]), 32'd250);
    chequear("def_bajo1", 32'(largos[2]), 32'd250);
    chequear("def_alto2", 32'(largos[3]), 32'd250);

    // Mid-ALTO load 4/1 takes effect from the second period.
    reiniciar();
    limpiar_monitor();
    hab = 1'b1;
    ciclos(20);
    carga(4, 1);
    chequear("err_tras_4_1", 32'(cerr), 32'd0);
    ciclos(800);
    chequear("p1_alto", 32'(largos[1]), 32'd250);
    chequear("p1_bajo", 32'(largos[2]), 32'd250);
    chequear("p2_alto", 32'(largos[3]), 32'd50);
    chequear("p2_bajo", 32'(largos[4]), 32'd150);

    // Rejected loads set the sticky error; a valid one clears it.
    reiniciar();
    limpiar_monitor();
    hab = 1'b1;
    ciclos(10);
    carga(5, 0);
    chequear("err_alto0", 32'(cerr), 32'd1);
    carga(8, 8);
    chequear("err_alto_eq", 32'(cerr), 32'd1);
    ciclos(1000);
    chequear("inval_alto", 32'(largos[1]), 32'd250);
    chequear("inval_bajo", 32'(largos[2]), 32'd250);
    carga(6, 2);
    chequear("err_limpio", 32'(cerr), 32'd0);
    ciclos(200);

    // habilitar dropped 30 clocks into ALTO: full period, then IDLE.
    reiniciar();
    limpiar_monitor();
    hab = 1'b1;
    ciclos(30);
    hab = 1'b0;
    ciclos(600);
    chequear("drop_alto", 32'(largos[1]), 32'd250);
    chequear("drop_tramos", 32'(largos.size()), 32'd2);
    chequear("drop_ocupado", 32'(ocup), 32'd0);
    chequear("drop_onda", 32'(onda), 32'd0);

    // Reset 100 clocks into BAJO after a 20/3 load: pending discarded.
    reiniciar();
    hab = 1'b1;
    ciclos(10);
    carga(20, 3);
    ciclos(339);
    rst = 1'b1;
    @(negedge clk);
    chequear("rst_onda", 32'(onda), 32'd0);
    chequear("rst_ocupado", 32'(ocup), 32'd0);
    chequear("rst_cfin", 32'(cfin), 32'd0);
    rst = 1'b0;
    limpiar_monitor();
    ciclos(1100);
    chequear("rst_alto", 32'(largos[1]), 32'd250);
    chequear("rst_bajo", 32'(largos[2]), 32'd250);

`ifdef GEN_RAFAGA_EN
    // Burst of 3 with habilitar held high, then re-arm by toggling.
    reiniciar();
    limpiar_monitor();
    npul = W'(3);
    hab  = 1'b1;
    ciclos(2000);
    chequear("raf_subidas", 32'(subidas), 32'd3);
    chequear("raf_fin", 32'(rafagas), 32'd1);
    chequear("raf_idle", 32'(ocup), 32'd0);
    hab = 1'b0;
    ciclos(2);
    hab = 1'b1;
    ciclos(3);
    chequear("raf_rearme", 32'(subidas), 32'd4);
    ciclos(1600);
`endif

    // Randomized phase; the model checks every cycle.
    reiniciar();
    hab = 1'b1;
    for (int it = 0; it < 40; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
`ifdef GEN_RAFAGA_EN
      npul = W'($urandom_range(0, 3));
`endif
      if (r < 6) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else if (r < 35) begin
        hab = ~hab;
      end else if (r < 75) begin
        carga(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
      end
      ciclos(int'($urandom_range(1, 300)));
    end
    hab = 1'b1;
    ciclos(800);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
